// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] round sequencer and state register feeding keccak_step_unit.
// Optional KECCAK_ROUND_CTRL_PERF_EN adds saturating run-cycle / job counters.
package keccak_pkg;
   localparam int unsigned ROW_SIZE         = 5;
   localparam int unsigned COL_SIZE         = 5;
   localparam int unsigned LANE_SIZE        = 64;
   localparam int unsigned STEP_SEL_WIDTH   = 3;
   localparam int unsigned ROUND_INDEX_SIZE = 5;

   localparam logic [STEP_SEL_WIDTH-1:0] IDLE_STEP  = 3'd0;
   localparam logic [STEP_SEL_WIDTH-1:0] THETA_STEP = 3'd1;
   localparam logic [STEP_SEL_WIDTH-1:0] RHO_STEP   = 3'd2;
   localparam logic [STEP_SEL_WIDTH-1:0] PI_STEP    = 3'd3;
   localparam logic [STEP_SEL_WIDTH-1:0] CHI_STEP   = 3'd4;
   localparam logic [STEP_SEL_WIDTH-1:0] IOTA_STEP  = 3'd5;
endpackage

module keccak_round_ctrl
   import keccak_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 24
)(
   input  logic                                                      clk,
   input  logic                                                      rst,
   input  logic                                                      s_valid_i,
   output logic                                                      s_ready_o,
   input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]          s_state_i,
   output logic                                                      m_valid_o,
   input  logic                                                      m_ready_i,
   output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]          m_state_o,
   output logic [STEP_SEL_WIDTH-1:0]                                 step_sel_o,
   output logic [ROUND_INDEX_SIZE-1:0]                               round_index_o,
   output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]          step_state_o,
   input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]          step_state_i,
   output logic                                                      busy_o
`ifdef KECCAK_ROUND_CTRL_PERF_EN
   ,
   output logic [15:0]                                               perf_cycles_o,
   output logic [15:0]                                               perf_jobs_o
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ROUND_INDEX_SIZE-1:0] LAST_ROUND = ROUND_INDEX_SIZE'(NUM_ROUNDS - 1);

   logic [1:0]                                             fsm_q, fsm_d;
   logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]       state_q, state_d;
   logic [STEP_SEL_WIDTH-1:0]                              step_q, step_d;
   logic [ROUND_INDEX_SIZE-1:0]                            round_q, round_d;

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      step_d  = step_q;
      round_d = round_q;
      unique case (fsm_q)
         ST_IDLE: begin
            if (s_valid_i) begin
               state_d = s_state_i;
               step_d  = THETA_STEP;
               round_d = '0;
               fsm_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            // The step unit only ever sees a real step here, so its result is always safe to latch.
            state_d = step_state_i;
            unique case (step_q)
               THETA_STEP: step_d = RHO_STEP;
               RHO_STEP:   step_d = PI_STEP;
               PI_STEP:    step_d = CHI_STEP;
               CHI_STEP:   step_d = IOTA_STEP;
               default: begin
                  step_d = THETA_STEP;
                  if (round_q == LAST_ROUND) begin
                     round_d = '0;
                     fsm_d   = ST_DONE;
                  end else begin
                     round_d = round_q + ROUND_INDEX_SIZE'(1);
                  end
               end
            endcase
         end
         ST_DONE: begin
            if (m_ready_i) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         step_q  <= THETA_STEP;
         round_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         step_q  <= step_d;
         round_q <= round_d;
      end
   end

   assign s_ready_o     = (fsm_q == ST_IDLE);
   assign busy_o        = (fsm_q == ST_RUN);
   assign m_valid_o     = (fsm_q == ST_DONE);
   assign step_sel_o    = (fsm_q == ST_RUN) ? step_q : IDLE_STEP;
   assign round_index_o = round_q;
   assign m_state_o     = state_q;
   assign step_state_o  = state_q;

`ifdef KECCAK_ROUND_CTRL_PERF_EN
   logic [15:0] perf_cycles_q, perf_jobs_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles_q <= '0;
         perf_jobs_q   <= '0;
      end else begin
         if ((fsm_q == ST_RUN) && (perf_cycles_q != '1))
            perf_cycles_q <= perf_cycles_q + 16'd1;
         if ((fsm_q == ST_DONE) && m_ready_i && (perf_jobs_q != '1))
            perf_jobs_q <= perf_jobs_q + 16'd1;
      end
   end

   assign perf_cycles_o = perf_cycles_q;
   assign perf_jobs_o   = perf_jobs_q;
`endif

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
Sequencer and state holder for the Keccak-f[1600] permutation. It sits directly upstream of the combinational keccak_step_unit. It latches an input state, then drives step_sel / round_index and the current state into the step unit, one step per cycle: theta, rho, pi, chi, iota for each round. It registers the step unit's result back every cycle and presents the permuted state on a valid/ready output port.

Parameters:
NUM_ROUNDS, 24, number of rounds executed; must be 1..24 and fit in ROUND_INDEX_SIZE.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
s_valid_i  input  1  input state valid
s_ready_o  output  1  block can accept an input state
s_state_i  input  ROW_SIZE*COL_SIZE*LANE_SIZE (packed [ROW][COL][LANE])  input state
m_valid_o  output  1  permuted state valid
m_ready_i  input  1  downstream accepts permuted state
m_state_o  output  same as s_state_i  permuted state (the internal state register)
step_sel_o  output  STEP_SEL_WIDTH  step select to keccak_step_unit
round_index_o  output  ROUND_INDEX_SIZE  round index to keccak_step_unit
step_state_o  output  same as s_state_i  state into keccak_step_unit (the internal state register)
step_state_i  input  same as s_state_i  keccak_step_unit result, same cycle
busy_o  output  1  high while in RUN

Behaviour:
- Clocking: single clock clk. rst is synchronous and active-high; it has priority over all other inputs.
- Reset values:
  - FSM enters IDLE; state register = 0; step counter = THETA_STEP; round counter = 0.
  - s_ready_o=1, m_valid_o=0, busy_o=0, step_sel_o=IDLE_STEP, round_index_o=0, m_state_o=step_state_o=0.
- FSM states: IDLE, RUN, DONE. All outputs decode from registered state; there are no combinational paths from inputs to outputs.
- IDLE:
  - s_ready_o=1; step_sel_o=IDLE_STEP.
  - On s_valid_i&&s_ready_o: state register <= s_state_i, step counter <= THETA_STEP, round <= 0, go to RUN.
- RUN:
  - s_ready_o=0, busy_o=1; step_sel_o = step counter; round_index_o = round counter.
  - Each cycle the state register <= step_state_i.
  - Step order: THETA->RHO->PI->CHI->IOTA->THETA. The round counter increments on the IOTA cycle.
  - On IOTA with round==NUM_ROUNDS-1: go to DONE; round counter and step counter reset to 0/THETA_STEP.
  - s_valid_i is ignored; no new input is accepted while running.
- DONE:
  - m_valid_o=1; m_state_o is stable; step_sel_o=IDLE_STEP; state register holds.
  - On m_ready_i: go to IDLE, m_valid_o deasserts the next cycle.
  - m_valid_o never drops without a handshake. No input is accepted in the same cycle as the output handshake.
- Latency:
  - Input handshake at cycle T; RUN occupies T+1..T+5*NUM_ROUNDS.
  - m_valid_o is first high at T+5*NUM_ROUNDS+1 (121 cycles for NUM_ROUNDS=24).
  - Throughput is one permutation per 5*NUM_ROUNDS+2 cycles with m_ready_i tied high.
- Step encodings, ROUND_INDEX_SIZE and STEP_SEL_WIDTH come from keccak_pkg.
- The round index is a plain binary count 0..NUM_ROUNDS-1 with no wrap beyond it. The index used for iota equals the index shown during that round's theta.
- Reset mid-operation (RUN or DONE):
  - Abandons the permutation; outputs return to reset values on the next cycle.
  - No m_valid_o pulse is produced for the aborted job.
- The step unit's IDLE_STEP output (zero) is never written into the state register.

Optional Feature:
KECCAK_ROUND_CTRL_PERF_EN
- Defined:
  - Adds output perf_cycles_o [15:0] and output perf_jobs_o [15:0].
  - perf_cycles_o counts cycles spent in RUN; perf_jobs_o counts completed output handshakes.
  - Both saturate at 16'hFFFF, clear on rst, and are not cleared by job start.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then all-zero s_state_i, NUM_ROUNDS=24, m_ready_i=1, with real keccak_step_unit attached:
  - m_valid_o is high exactly 121 cycles after the input handshake.
  - Lane [0][0] = 64'hF1258F7940E1DDE7, matching the Keccak-f[1600] reference model for all 25 lanes.
- Step sequencing, observed over RUN:
  - step_sel_o cycles THETA,RHO,PI,CHI,IOTA exactly 24 times.
  - round_index_o steps 0..23, changing only after IOTA.
  - busy_o is high for exactly 120 cycles.
- Backpressure: hold m_ready_i=0 for 10 cycles after m_valid_o rises.
  - m_valid_o stays 1 and m_state_o stays constant; s_ready_o stays 0.
  - After m_ready_i=1, IDLE is reached and s_ready_o=1 the next cycle.
- Input during RUN: pulse s_valid_i with a random state at RUN cycle 30.
  - Ignored: the result still equals the model of the first input.
  - The next job is accepted only once back in IDLE.
- Reset mid-run: assert rst at RUN cycle 50 for one cycle.
  - Next cycle: step_sel_o=IDLE_STEP, busy_o=0, s_ready_o=1, m_state_o=0, and no m_valid_o pulse.
  - A fresh job then completes correctly.
- With KECCAK_ROUND_CTRL_PERF_EN: two back-to-back jobs give perf_cycles_o=240 and perf_jobs_o=2.
  - rst clears both to 0.
